banco_registros: RTL



---
 rtl/banco_registros_pkg.sv | 11 +
 rtl/banco_registros_if.sv | 25 ++
 rtl/banco_registros_decodificador_escritura.sv | 16 +
 rtl/banco_registros.sv | 62 ++++++
 4 files changed

// File: rtl/banco_registros_pkg.sv
// Shared definitions for the register file and the address multiplexers
// that feed it (rs / rt / ra selection).
package banco_registros_pkg;
  localparam int ADDR_W     = 5;
  localparam int DATA_W_DEF = 32;
  localparam int N_REGS_DEF = 32;
  localparam int CNT_W      = 16;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/banco_registros_if.sv
// Register file access bus: two read ports, one write port, write counter.
interface banco_registros_if
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] a1;
  logic [ADDR_W-1:0] a2;
  logic [ADDR_W-1:0] a3;
  logic              we3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output a1, a2, a3, we3, wd3,
    input  rd1, rd2, wr_count
  );

  modport slave (
    input  a1, a2, a3, we3, wd3,
    output rd1, rd2, wr_count
  );
endinterface

// File: rtl/banco_registros_decodificador_escritura.sv
// One-hot write-enable decoder; register 0 can never be selected.
module decodificador_escritura
  import banco_registros_pkg::*;
#(
  parameter int N_REGS = N_REGS_DEF
) (
  input  logic              we3,
  input  logic [ADDR_W-1:0] a3,
  output logic [N_REGS-1:0] wen
);
  assign wen[0] = 1'b0;

  for (genvar i = 1; i < N_REGS; i++) begin : g_dec
    assign wen[i] = we3 && (a3 == ADDR_W'(i));
  end
endmodule

// File: rtl/banco_registros.sv
// Register file: flop storage with async clear, combinational reads with
// write-through bypass, and a wrapping count of committed writes.
module banco_registros
  import banco_registros_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int N_REGS = N_REGS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  banco_registros_if.slave  bus
);
  logic [N_REGS-1:0] wen;
  logic [DATA_W-1:0] regs [1:N_REGS-1];
  logic [CNT_W-1:0]  cnt;
  logic              commit;

  decodificador_escritura #(.N_REGS(N_REGS)) u_dec (
    .we3 (bus.we3),
    .a3  (bus.a3),
    .wen (wen)
  );

  // wen[0] is always low, so any set bit is a write to a real register.
  assign commit = |wen;

  // Storage: register 0 has no flops; the rest clear asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < N_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < N_REGS; i++)
        if (wen[i]) regs[i] <= bus.wd3;
    end
  end

  // Committed-write counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         cnt <= '0;
    else if (commit) cnt <= cnt + 1'b1;
  end

  assign bus.wr_count = cnt;

  // Read port 1: zero on reset or r0, bypass on a matching write.
  always_comb begin
    bus.rd1 = '0;
    if (!rst && bus.a1 != REG_ZERO && int'(bus.a1) < N_REGS) begin
      if (bus.we3 && bus.a1 == bus.a3) bus.rd1 = bus.wd3;
      else                             bus.rd1 = regs[bus.a1];
    end
  end

  // Read port 2: same rules as port 1, fully independent.
  always_comb begin
    bus.rd2 = '0;
    if (!rst && bus.a2 != REG_ZERO && int'(bus.a2) < N_REGS) begin
      if (bus.we3 && bus.a2 == bus.a3) bus.rd2 = bus.wd3;
      else                             bus.rd2 = regs[bus.a2];
    end
  end
endmodule
